// File: rtl/sv32_walk_arbiter_if.sv
// Requester, flush and walker-side signals of the sv32 walk arbiter.
// slave is the arbiter's view; master is the view of the core/walker around it.
interface sv32_walk_arbiter_if;
  logic        i_valid;
  logic [31:0] i_address;
  logic        i_ready;
  logic [31:0] i_pte;
  logic        d_valid;
  logic [31:0] d_address;
  logic        d_ready;
  logic [31:0] d_pte;
  logic        flush_req;
  logic        flush_ack;
  logic        walk_valid;
  logic        walk_ready;
  logic [31:0] walk_address;
  logic        walk_is_instruction;
  logic [31:0] walk_pte;
  logic        walk_tlb_flush;

  modport slave (
    input  i_valid, i_address, d_valid, d_address, flush_req, walk_ready, walk_pte,
    output i_ready, i_pte, d_ready, d_pte, flush_ack,
           walk_valid, walk_address, walk_is_instruction, walk_tlb_flush
  );

  modport master (
    output i_valid, i_address, d_valid, d_address, flush_req, walk_ready, walk_pte,
    input  i_ready, i_pte, d_ready, d_pte, flush_ack,
           walk_valid, walk_address, walk_is_instruction, walk_tlb_flush
  );
endinterface

// File: rtl/sv32_walk_arbiter.sv
// Shares one sv32 table walker between fetch and data translation, round-robin
// on ties, and sequences TLB flushes so they never cut into a walk.
module sv32_walk_arbiter #(
  parameter int CNT_WIDTH    = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  sv32_walk_arbiter_if.slave   bus,
  output logic [CNT_WIDTH-1:0] walk_count_i,
  output logic [CNT_WIDTH-1:0] walk_count_d
);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, FLUSH} state_t;

  typedef struct packed {
    logic        is_i;
    logic [31:0] addr;
  } walk_req_t;

  state_t         state, state_nxt;
  walk_req_t      req_q;
  logic           last_grant;  // 1 = data was granted last
  logic [FCW-1:0] flush_cnt, flush_cnt_nxt;
  logic           grant_en, grant_d, complete;
  logic           i_ready_q, d_ready_q;
  logic [31:0]    i_pte_q, d_pte_q;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    grant_en      = 1'b0;
    grant_d       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.flush_req) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FCW'(FLUSH_CYCLES);
        end else if (bus.i_valid || bus.d_valid) begin
          grant_en  = 1'b1;
          // on a tie, data wins only if fetch was granted last
          grant_d   = bus.d_valid && (!bus.i_valid || !last_grant);
          state_nxt = BUSY;
        end
      end
      BUSY:  if (bus.walk_ready) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      FLUSH: begin
        flush_cnt_nxt = flush_cnt - FCW'(1);
        if (flush_cnt == FCW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign complete = (state == BUSY) && bus.walk_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      req_q        <= '0;
      last_grant   <= 1'b1;
      flush_cnt    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_pte_q      <= '0;
      d_pte_q      <= '0;
      walk_count_i <= '0;
      walk_count_d <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      if (grant_en) begin
        req_q      <= '{is_i: !grant_d, addr: grant_d ? bus.d_address : bus.i_address};
        last_grant <= grant_d;
      end
      // a requester that has given up still gets its walk counted, but no ready
      if (complete) begin
        if (req_q.is_i) begin
          i_pte_q      <= bus.walk_pte;
          i_ready_q    <= bus.i_valid;
          walk_count_i <= walk_count_i + CNT_WIDTH'(1);
        end else begin
          d_pte_q      <= bus.walk_pte;
          d_ready_q    <= bus.d_valid;
          walk_count_d <= walk_count_d + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.walk_valid          = (state == BUSY);
  assign bus.walk_address        = req_q.addr;
  assign bus.walk_is_instruction = req_q.is_i;
  assign bus.walk_tlb_flush      = (state == FLUSH);
  assign bus.flush_ack           = (state == FLUSH) && (flush_cnt == FCW'(1));
  assign bus.i_ready             = i_ready_q;
  assign bus.i_pte               = i_pte_q;
  assign bus.d_ready             = d_ready_q;
  assign bus.d_pte               = d_pte_q;
endmodule
